header_seeker_lock: RTL and testbench
=====================================

HEADER_SEEKER_LOCK -- requirements
Module: header_seeker_lock

Interface
REQ-001 The block SHALL expose parameter BLOCK_W, default 66, meaning 66b block length and number of candidate header offsets.
REQ-002 The block SHALL expose parameter NUM_SEEKERS, default 2, meaning parallel seekers, 1..8, dividing BLOCK_W.
REQ-003 The block SHALL expose parameter LOCK_CNT, default 64, meaning consecutive valid headers required to lock.
REQ-004 The block SHALL expose parameter BAD_WIN, default 64, meaning checks per bad-header monitoring window while locked.
REQ-005 The block SHALL expose parameter UNLOCK_BAD, default 16, meaning bad headers within one window that force unlock.
REQ-006 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-008 The block SHALL have port slice_i, input, BLOCK_W+1 bits: gearbox slice guaranteed to contain one header.
REQ-009 The block SHALL have port slice_valid_i, input, 1 bit: slice_i is valid this cycle, one check per seeker.
REQ-010 The block SHALL have port resync_i, input, 1 bit: synchronous request to drop lock and restart search.
REQ-011 The block SHALL have port block_offset_o, output, $clog2(BLOCK_W) bits: header offset of the locked seeker.
REQ-012 The block SHALL have port lock_o, output, 1 bit: block lock achieved.
REQ-013 The block SHALL have port lock_lost_o, output, 1 bit: one-cycle pulse on LOCKED->SEARCH.
REQ-014 The block SHALL have port lock_loss_cnt_o, output, 8 bits: saturating count of lock losses.

Function
REQ-015 Header at offset p SHALL be {slice_i[p+1], slice_i[p]}; valid iff 2'b01 or 2'b10; p ranges 0..BLOCK_W-1.
REQ-016 Seeker k SHALL hold position pos[k] and good counter good[k]; its start position is k*(BLOCK_W/NUM_SEEKERS).
REQ-017 The FSM SHALL have states SEARCH and LOCKED; checks occur only on cycles with slice_valid_i=1.
REQ-018 In SEARCH, a seeker with a valid header SHALL increment good[k], saturating at LOCK_CNT.
REQ-019 In SEARCH, a seeker with an invalid header SHALL clear good[k] and advance pos[k] by 1, wrapping BLOCK_W-1 -> 0.
REQ-020 SEARCH->LOCKED SHALL occur at the edge where any good[k] reaches LOCK_CNT; lowest index wins on ties; the chosen index is latched.
REQ-021 lock_o SHALL assert, and block_offset_o SHALL equal pos[chosen], in the cycle after the LOCK_CNT-th consecutive valid slice.
REQ-022 In LOCKED, only the chosen seeker is checked; its position SHALL not move; other seekers hold their state.
REQ-023 In LOCKED, the window counter SHALL count checks 0..BAD_WIN-1, and the bad counter SHALL count invalid headers; both clear when the window wraps.
REQ-024 The bad count reaching UNLOCK_BAD SHALL, at that edge, enter SEARCH, deassert lock_o, and pulse lock_lost_o for 1 cycle.
REQ-025 A BAD_WIN-th check that is itself the UNLOCK_BAD-th bad SHALL unlock (unlock takes precedence over window clear).
REQ-026 On entering SEARCH from any cause, all seekers SHALL reload their start positions and clear good; the chosen seeker's pos SHALL advance by 1 (wrapping) so the failed offset is not retried first.
REQ-027 resync_i=1 SHALL force SEARCH at the next edge and override a same-cycle lock; lock_lost_o pulses only if the state was LOCKED.
REQ-028 block_offset_o SHALL hold its last value while in SEARCH.

Reset
REQ-029 rst_ni low SHALL immediately put the FSM in SEARCH and force lock_o=0, lock_lost_o=0, block_offset_o=0, lock_loss_cnt_o=0.
REQ-030 rst_ni low SHALL immediately reload all seekers to their start positions and clear good, window and bad counters.
REQ-031 Reset SHALL be asserted asynchronously and released synchronously to clk_i externally; reset mid-lock SHALL not pulse lock_lost_o.

Configuration
REQ-032 Macro SEEKER_LOSS_STATS_EN defined SHALL make lock_loss_cnt_o increment once per lock_lost_o pulse and saturate at 255.
REQ-033 Without SEEKER_LOSS_STATS_EN, lock_loss_cnt_o SHALL be tied to 0 and no counter flops SHALL exist.

Verification
REQ-034 The bench SHALL apply defaults with the true header at offset 5 and 64 valid slices -> seeker0 reaches 5 after 5 bad checks; lock_o=1 with block_offset_o=5 one cycle after the 64th good slice of seeker0.
REQ-035 The bench SHALL apply a header at offset 40 -> seeker1, starting at 33, locks first; block_offset_o=40.
REQ-036 The bench SHALL, while locked, inject 15 bad headers in one 64-check window -> lock is held; injecting 16 -> lock_o=0 and lock_lost_o pulses 1 cycle.
REQ-037 The bench SHALL, while locked, assert resync_i for 1 cycle -> SEARCH at the next edge, lock_o=0, counter +1 (macro on) or 0 (macro off).
REQ-038 The bench SHALL cover a header at offset 65 with seekers wrapping 65->0 and rst_ni asserted mid-search -> all outputs 0 immediately; after release, relock at 65.

Source files
------------

// File: rtl/header_seeker_lock.sv
// Block-lock search for 66b framing: parallel seekers hunt for a valid 2-bit sync header offset, then the chosen one is monitored for bad headers.
// Optional lock-loss statistics counter is built when SEEKER_LOSS_STATS_EN is defined.
module header_seeker_lock #(
    parameter int BLOCK_W     = 66,
    parameter int NUM_SEEKERS = 2,
    parameter int LOCK_CNT    = 64,
    parameter int BAD_WIN     = 64,
    parameter int UNLOCK_BAD  = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [BLOCK_W:0]           slice_i,
    input  logic                       slice_valid_i,
    input  logic                       resync_i,
    output logic [$clog2(BLOCK_W)-1:0] block_offset_o,
    output logic                       lock_o,
    output logic                       lock_lost_o,
    output logic [7:0]                 lock_loss_cnt_o
);
    localparam int POS_W  = $clog2(BLOCK_W);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W  = $clog2(BAD_WIN + 1);
    localparam int BAD_W  = $clog2(UNLOCK_BAD + 1);
    localparam int SEL_W  = (NUM_SEEKERS > 1) ? $clog2(NUM_SEEKERS) : 1;
    localparam int STRIDE = BLOCK_W / NUM_SEEKERS;

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t            state;
    logic [POS_W-1:0]  pos  [NUM_SEEKERS];
    logic [GOOD_W-1:0] good [NUM_SEEKERS];
    logic [SEL_W-1:0]  chosen;
    logic [WIN_W-1:0]  win_cnt;
    logic [BAD_W-1:0]  bad_cnt;

    function automatic logic [POS_W-1:0] start_pos(input int k);
        return POS_W'(k * STRIDE);
    endfunction

    function automatic logic [POS_W-1:0] pos_inc(input logic [POS_W-1:0] p);
        return (p == POS_W'(BLOCK_W - 1)) ? '0 : p + POS_W'(1);
    endfunction

    function automatic logic [GOOD_W-1:0] good_inc(input logic [GOOD_W-1:0] g);
        return (g == GOOD_W'(LOCK_CNT)) ? g : g + GOOD_W'(1);
    endfunction

    logic [NUM_SEEKERS-1:0] hdr_valid;
    logic [NUM_SEEKERS-1:0] hit_lock;
    logic                   any_hit;
    logic [SEL_W-1:0]       hit_idx;
    logic                   chosen_ok;
    logic [BAD_W-1:0]       bad_nxt;
    logic                   unlock_bad;
    logic                   drop_lock;
    logic                   lost_evt;

    always_comb begin
        hdr_valid = '0;
        hit_lock  = '0;
        any_hit   = 1'b0;
        hit_idx   = '0;
        for (int k = 0; k < NUM_SEEKERS; k++) begin
            hdr_valid[k] = slice_i[pos[k] + 1] ^ slice_i[pos[k]];
            hit_lock[k]  = hdr_valid[k] && (good[k] == GOOD_W'(LOCK_CNT - 1));
        end
        // Descending scan so the lowest-index hit is the one left in hit_idx.
        for (int k = NUM_SEEKERS - 1; k >= 0; k--) begin
            if (hit_lock[k]) begin
                any_hit = 1'b1;
                hit_idx = SEL_W'(k);
            end
        end
    end

    assign chosen_ok  = hdr_valid[chosen];
    assign bad_nxt    = bad_cnt + BAD_W'(!chosen_ok);
    assign unlock_bad = (state == LOCKED) && slice_valid_i && !chosen_ok &&
                        (bad_nxt == BAD_W'(UNLOCK_BAD));
    assign drop_lock  = resync_i || unlock_bad;
    assign lost_evt   = (state == LOCKED) && drop_lock;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= SEARCH;
            lock_o         <= 1'b0;
            lock_lost_o    <= 1'b0;
            block_offset_o <= '0;
            chosen         <= '0;
            win_cnt        <= '0;
            bad_cnt        <= '0;
            for (int k = 0; k < NUM_SEEKERS; k++) begin
                pos[k]  <= start_pos(k);
                good[k] <= '0;
            end
        end else begin
            lock_lost_o <= lost_evt;
            if (drop_lock) begin
                state   <= SEARCH;
                lock_o  <= 1'b0;
                win_cnt <= '0;
                bad_cnt <= '0;
                for (int k = 0; k < NUM_SEEKERS; k++) begin
                    good[k] <= '0;
                    // Skip past the offset that just failed instead of retrying it first.
                    if ((state == LOCKED) && (SEL_W'(k) == chosen))
                        pos[k] <= pos_inc(pos[k]);
                    else
                        pos[k] <= start_pos(k);
                end
            end else if (state == SEARCH) begin
                if (slice_valid_i) begin
                    for (int k = 0; k < NUM_SEEKERS; k++) begin
                        if (hdr_valid[k]) begin
                            good[k] <= good_inc(good[k]);
                        end else begin
                            good[k] <= '0;
                            pos[k]  <= pos_inc(pos[k]);
                        end
                    end
                    if (any_hit) begin
                        state          <= LOCKED;
                        lock_o         <= 1'b1;
                        chosen         <= hit_idx;
                        block_offset_o <= pos[hit_idx];
                        win_cnt        <= '0;
                        bad_cnt        <= '0;
                    end
                end
            end else if (slice_valid_i) begin
                if (win_cnt == WIN_W'(BAD_WIN - 1)) begin
                    win_cnt <= '0;
                    bad_cnt <= '0;
                end else begin
                    win_cnt <= win_cnt + WIN_W'(1);
                    bad_cnt <= bad_nxt;
                end
            end
        end
    end

`ifdef SEEKER_LOSS_STATS_EN
    logic [7:0] loss_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            loss_cnt <= '0;
        else if (lost_evt && (loss_cnt != 8'hFF))
            loss_cnt <= loss_cnt + 8'd1;
    end

    assign lock_loss_cnt_o = loss_cnt;
`else
    assign lock_loss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_header_seeker_lock.sv
// Randomized bench for header_seeker_lock against a cycle-level reference model of the lock rules.
module tb_header_seeker_lock;
    localparam int BW   = 66;
    localparam int NS   = 2;
    localparam int LC   = 64;
    localparam int BWIN = 64;
    localparam int UB   = 16;
    localparam int PW   = $clog2(BW);

`ifdef SEEKER_LOSS_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef logic [BW:0] slice_t;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    slice_t        slice_i;
    logic          slice_valid_i;
    logic          resync_i;
    logic [PW-1:0] block_offset_o;
    logic          lock_o;
    logic          lock_lost_o;
    logic [7:0]    lock_loss_cnt_o;

    header_seeker_lock #(
        .BLOCK_W(BW), .NUM_SEEKERS(NS), .LOCK_CNT(LC), .BAD_WIN(BWIN), .UNLOCK_BAD(UB)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .slice_i(slice_i), .slice_valid_i(slice_valid_i),
        .resync_i(resync_i), .block_offset_o(block_offset_o), .lock_o(lock_o),
        .lock_lost_o(lock_lost_o), .lock_loss_cnt_o(lock_loss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: seekers described as plain integer positions and run lengths.
    int m_pos [NS];
    int m_good[NS];
    bit m_locked, m_lock, m_lost;
    int m_chosen, m_win, m_bad, m_off, m_cnt;

    function automatic bit hdr_at(input slice_t s, input int p);
        return s[p+1] ^ s[p];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NS; k++) begin
            m_pos[k]  = k * (BW / NS);
            m_good[k] = 0;
        end
        m_locked = 0; m_lock = 0; m_lost = 0;
        m_chosen = 0; m_win = 0; m_bad = 0; m_off = 0; m_cnt = 0;
    endtask

    task automatic model_edge(input slice_t s, input bit v, input bit rs);
        bit unlock;
        int hit;
        m_lost = 0;
        unlock = m_locked && v && !hdr_at(s, m_pos[m_chosen]) && (m_bad + 1 >= UB);
        if (rs || unlock) begin
            if (m_locked) begin
                m_lost = 1;
                if (STATS && m_cnt < 255) m_cnt++;
            end
            for (int k = 0; k < NS; k++) begin
                if (m_locked && k == m_chosen) m_pos[k] = (m_pos[k] + 1) % BW;
                else                           m_pos[k] = k * (BW / NS);
                m_good[k] = 0;
            end
            m_locked = 0; m_lock = 0; m_win = 0; m_bad = 0;
        end else if (!m_locked && v) begin
            hit = -1;
            for (int k = 0; k < NS; k++) begin
                if (hdr_at(s, m_pos[k])) begin
                    m_good[k] = (m_good[k] + 1 > LC) ? LC : m_good[k] + 1;
                    if (m_good[k] == LC && hit < 0) hit = k;
                end else begin
                    m_good[k] = 0;
                    m_pos[k]  = (m_pos[k] + 1) % BW;
                end
            end
            if (hit >= 0) begin
                m_locked = 1; m_lock = 1; m_chosen = hit; m_off = m_pos[hit];
                m_win = 0; m_bad = 0;
            end
        end else if (m_locked && v) begin
            if (!hdr_at(s, m_pos[m_chosen])) m_bad++;
            m_win++;
            if (m_win == BWIN) begin
                m_win = 0;
                m_bad = 0;
            end
        end
    endtask

    task automatic compare_all();
        chk("lock", int'(lock_o), int'(m_lock));
        chk("offset", int'(block_offset_o), m_off);
        chk("lost", int'(lock_lost_o), int'(m_lost));
        chk("loss_cnt", int'(lock_loss_cnt_o), m_cnt);
    endtask

    // Header at h; clean slices make every other offset an invalid 00/11 pair.
    function automatic slice_t mk_slice(input int h, input bit pol, input bit clean, input bit bad);
        slice_t s;
        s = slice_t'({$urandom(), $urandom(), $urandom()});
        s[h]   = pol;
        s[h+1] = bad ? pol : ~pol;
        if (clean) begin
            for (int i = 0; i <= BW; i++) begin
                if (i < h)          s[i] = s[h];
                else if (i > h + 1) s[i] = s[h+1];
            end
        end
        return s;
    endfunction

    task automatic step(input slice_t s, input bit v, input bit rs);
        @(negedge clk_i);
        slice_i = s; slice_valid_i = v; resync_i = rs;
        @(posedge clk_i);
        model_edge(s, v, rs);
        #1;
        compare_all();
    endtask

    task automatic async_reset();
        @(negedge clk_i);
        slice_valid_i = 1'b0; resync_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        model_reset();
        #1;
        chk("rst_lock", int'(lock_o), 0);
        chk("rst_offset", int'(block_offset_o), 0);
        chk("rst_lost", int'(lock_lost_o), 0);
        chk("rst_cnt", int'(lock_loss_cnt_o), 0);
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_hold_lost", int'(lock_lost_o), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic run_until_lock(input int h, input int budget, output int n);
        bit done = 0;
        n = 0;
        for (int i = 0; i < budget && !done; i++) begin
            step(mk_slice(h, 1'($urandom), 1'b1, 1'b0), 1'b1, 1'b0);
            n++;
            if (lock_o) done = 1;
        end
        if (!done) chk("lock_timeout", 0, 1);
    endtask

    task automatic bad_window(input int h, input int nbad, output int lost_seen);
        bit mask[BWIN];
        bit t;
        int j;
        bit stop = 0;
        for (int i = 0; i < BWIN; i++) mask[i] = (i < nbad);
        for (int i = BWIN - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = mask[i]; mask[i] = mask[j]; mask[j] = t;
        end
        lost_seen = 0;
        for (int i = 0; i < BWIN && !stop; i++) begin
            if ($urandom_range(0, 3) == 0)
                step(mk_slice(h, 1'($urandom), 1'b1, 1'b1), 1'b0, 1'b0);
            step(mk_slice(h, 1'($urandom), 1'b1, mask[i]), 1'b1, 1'b0);
            if (lock_lost_o) lost_seen++;
            if (!lock_o) stop = 1;
        end
    endtask

    initial begin
        int n, ls, h, seg, badp;
        bit clean;
        rst_ni = 1'b0; slice_i = '0; slice_valid_i = 1'b0; resync_i = 1'b0;
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_lock", int'(lock_o), 0);
        chk("reset_offset", int'(block_offset_o), 0);
        chk("reset_lost", int'(lock_lost_o), 0);
        chk("reset_cnt", int'(lock_loss_cnt_o), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        run_until_lock(5, 300, n);
        chk("lock_lat_off5", n, 69);
        chk("offset_off5", int'(block_offset_o), 5);

        bad_window(5, 15, ls);
        chk("bad15_lock_held", int'(lock_o), 1);
        chk("bad15_no_lost", ls, 0);
        bad_window(5, 16, ls);
        chk("bad16_lock_drop", int'(lock_o), 0);
        chk("bad16_lost_pulse", ls, 1);
        step(mk_slice(5, 1'($urandom), 1'b1, 1'b0), 1'b1, 1'b0);
        chk("lost_one_cycle", int'(lock_lost_o), 0);

        run_until_lock(5, 300, n);
        chk("relock_off5", int'(block_offset_o), 5);
        step(mk_slice(5, 1'($urandom), 1'b1, 1'b0), 1'b1, 1'b1);
        chk("resync_lock", int'(lock_o), 0);
        chk("resync_lost", int'(lock_lost_o), 1);
        chk("resync_cnt", int'(lock_loss_cnt_o), STATS ? 2 : 0);

        // Resync on the very edge that would lock must win.
        async_reset();
        for (int i = 0; i < 68; i++) step(mk_slice(5, 1'($urandom), 1'b1, 1'b0), 1'b1, 1'b0);
        chk("no_early_lock", int'(lock_o), 0);
        step(mk_slice(5, 1'($urandom), 1'b1, 1'b0), 1'b1, 1'b1);
        chk("resync_beats_lock", int'(lock_o), 0);
        chk("resync_search_nolost", int'(lock_lost_o), 0);

        async_reset();
        run_until_lock(40, 300, n);
        chk("lock_lat_off40", n, 71);
        chk("offset_off40", int'(block_offset_o), 40);

        async_reset();
        for (int i = 0; i < 20; i++) step(mk_slice(65, 1'($urandom), 1'b1, 1'b0), 1'b1, 1'b0);
        async_reset();
        run_until_lock(65, 300, n);
        chk("lock_lat_off65", n, 96);
        chk("offset_off65", int'(block_offset_o), 65);
        bad_window(65, 16, ls);
        chk("off65_unlock", int'(lock_o), 0);
        run_until_lock(65, 400, n);
        chk("relock_wrap_lat", n, 129);
        chk("relock_wrap_off", int'(block_offset_o), 65);

        seg = 0; h = 0; badp = 0; clean = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (seg == 0) begin
                seg   = $urandom_range(50, 400);
                h     = $urandom_range(0, BW - 1);
                clean = 1'($urandom);
                case ($urandom_range(0, 2))
                    0:       badp = 0;
                    1:       badp = 64;
                    default: badp = 3;
                endcase
            end
            seg--;
            if ($urandom_range(0, 1999) == 0)
                async_reset();
            else
                step(mk_slice(h, 1'($urandom), clean, (badp != 0) && ($urandom_range(1, badp) == 1)),
                     $urandom_range(0, 7) != 0, $urandom_range(0, 299) == 0);
        end

        async_reset();
        for (int i = 0; i < 256; i++) begin
            run_until_lock($urandom_range(0, BW - 1), 400, n);
            step(mk_slice(0, 1'b0, 1'b1, 1'b1), 1'b0, 1'b1);
        end
        chk("loss_cnt_saturate", int'(lock_loss_cnt_o), STATS ? 255 : 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
